// File: rtl/neighbor_builder.sv
// ============================================================================
// Module   : neighbor_builder
// Brief    : Walks the face list in object RAM and builds a deduplicated
//            per-vertex neighbour table in neighbour RAM. Optional corner
//            range checking is enabled by defining NBR_RANGE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module neighbor_builder #(
    parameter int MAX_NEIGHBOR_COUNT = 10,
    parameter int ADDR_WIDTH         = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           vertex_count,
    input  logic [31:0]           face_count,
    input  logic [31:0]           RAM_OBJ_Do,
    input  logic [31:0]           RAM_NBR_Do,
    output logic                  RAM_OBJ_EN,
    output logic                  RAM_NBR_EN,
    output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
    output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
    output logic [3:0]            RAM_OBJ_WE,
    output logic [3:0]            RAM_NBR_WE,
    output logic [31:0]           RAM_OBJ_Di,
    output logic [31:0]           RAM_NBR_Di,
    output logic                  busy,
    output logic                  overflow,
    output logic                  bad_index
);

    localparam logic [3:0] c_st_idle      = 4'd0;
    localparam logic [3:0] c_st_clear     = 4'd1;
    localparam logic [3:0] c_st_fetch     = 4'd2;
    localparam logic [3:0] c_st_check     = 4'd3;
    localparam logic [3:0] c_st_pair      = 4'd4;
    localparam logic [3:0] c_st_read_cnt  = 4'd5;
    localparam logic [3:0] c_st_scan      = 4'd6;
    localparam logic [3:0] c_st_decide    = 4'd7;
    localparam logic [3:0] c_st_write_cnt = 4'd8;
    localparam logic [3:0] c_st_done      = 4'd9;

    localparam logic [ADDR_WIDTH-1:0] c_rec_words = ADDR_WIDTH'(MAX_NEIGHBOR_COUNT);
    localparam logic [ADDR_WIDTH-1:0] c_max_nbrs  = ADDR_WIDTH'(MAX_NEIGHBOR_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] c_one       = ADDR_WIDTH'(1);
    localparam logic [3:0]            c_we_all    = 4'b1111;
    localparam logic [2:0]            c_pairs_end = 3'd6;

    logic [3:0]            r_state;
    logic                  r_busy;
    logic                  r_overflow;
    logic                  r_obj_en;
    logic                  r_nbr_en;
    logic [ADDR_WIDTH-1:0] r_obj_a;
    logic [ADDR_WIDTH-1:0] r_nbr_a;
    logic [3:0]            r_nbr_we;
    logic [31:0]           r_nbr_di;
    logic [31:0]           r_vcnt;
    logic [31:0]           r_fcnt;
    logic [31:0]           r_v;
    logic [31:0]           r_f;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic [ADDR_WIDTH-1:0] r_face_addr;
    logic [1:0]            r_sub;
    logic [31:0]           r_a;
    logic [31:0]           r_b;
    logic [31:0]           r_c;
    logic [2:0]            r_pair;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [31:0]           r_t;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_idx;

    logic [31:0]           w_s;
    logic [31:0]           w_t;
    logic [ADDR_WIDTH-1:0] w_s_base;
    logic [ADDR_WIDTH-1:0] w_v_lo;
    logic [ADDR_WIDTH-1:0] w_face0_addr;
    logic [ADDR_WIDTH-1:0] w_do_cnt;

    // Record base for a 1-based vertex index; wraps in ADDR_WIDTH bits.
    function automatic logic [ADDR_WIDTH-1:0] rec_base(input logic [ADDR_WIDTH-1:0] idx);
        return (idx - c_one) * c_rec_words;
    endfunction

    always_comb begin
        w_s = r_a;
        w_t = r_b;
        case (r_pair)
            3'd0:    begin w_s = r_a; w_t = r_b; end
            3'd1:    begin w_s = r_a; w_t = r_c; end
            3'd2:    begin w_s = r_b; w_t = r_a; end
            3'd3:    begin w_s = r_b; w_t = r_c; end
            3'd4:    begin w_s = r_c; w_t = r_a; end
            3'd5:    begin w_s = r_c; w_t = r_b; end
            default: begin w_s = r_a; w_t = r_b; end
        endcase
    end

    assign w_s_base     = rec_base(w_s[ADDR_WIDTH-1:0]);
    assign w_v_lo       = vertex_count[ADDR_WIDTH-1:0];
    assign w_face0_addr = w_v_lo + (w_v_lo << 1) + c_one;
    assign w_do_cnt     = RAM_NBR_Do[ADDR_WIDTH-1:0];

`ifdef NBR_RANGE_CHECK_EN
    logic r_bad_index;
    logic w_face_bad;

    assign w_face_bad = (r_a == 32'd0) || (r_a > r_vcnt) ||
                        (r_b == 32'd0) || (r_b > r_vcnt) ||
                        (r_c == 32'd0) || (r_c > r_vcnt);
    assign bad_index  = r_bad_index;
`else
    assign bad_index  = 1'b0;
`endif

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_busy      <= 1'b0;
            r_overflow  <= 1'b0;
            r_obj_en    <= 1'b0;
            r_nbr_en    <= 1'b0;
            r_obj_a     <= '0;
            r_nbr_a     <= '0;
            r_nbr_we    <= '0;
            r_nbr_di    <= '0;
            r_vcnt      <= '0;
            r_fcnt      <= '0;
            r_v         <= '0;
            r_f         <= '0;
            r_clr_addr  <= '0;
            r_face_addr <= '0;
            r_sub       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_pair      <= '0;
            r_base      <= '0;
            r_t         <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
`ifdef NBR_RANGE_CHECK_EN
            r_bad_index <= 1'b0;
`endif
        end else begin
            r_nbr_we <= '0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_busy      <= 1'b1;
                        r_overflow  <= 1'b0;
`ifdef NBR_RANGE_CHECK_EN
                        r_bad_index <= 1'b0;
`endif
                        r_obj_en    <= 1'b1;
                        r_nbr_en    <= 1'b1;
                        r_vcnt      <= vertex_count;
                        r_fcnt      <= face_count;
                        r_v         <= '0;
                        r_f         <= '0;
                        r_clr_addr  <= '0;
                        r_face_addr <= w_face0_addr;
                        r_state     <= c_st_clear;
                    end
                end

                c_st_clear: begin
                    if (r_v == r_vcnt) begin
                        if (r_fcnt == 32'd0) begin
                            r_busy   <= 1'b0;
                            r_obj_en <= 1'b0;
                            r_nbr_en <= 1'b0;
                            r_state  <= c_st_done;
                        end else begin
                            r_sub   <= '0;
                            r_state <= c_st_fetch;
                        end
                    end else begin
                        r_nbr_a    <= r_clr_addr;
                        r_nbr_di   <= '0;
                        r_nbr_we   <= c_we_all;
                        r_clr_addr <= r_clr_addr + c_rec_words;
                        r_v        <= r_v + 32'd1;
                    end
                end

                // Corner k's address goes out on step k; its data lands one step later.
                c_st_fetch: begin
                    if (r_sub != 2'd3) begin
                        r_obj_a <= r_face_addr + ADDR_WIDTH'(r_sub);
                    end
                    case (r_sub)
                        2'd1:    r_a <= RAM_OBJ_Do;
                        2'd2:    r_b <= RAM_OBJ_Do;
                        2'd3:    r_c <= RAM_OBJ_Do;
                        default: ;
                    endcase
                    r_sub <= r_sub + 2'd1;
                    if (r_sub == 2'd3) begin
                        r_pair  <= '0;
                        r_state <= c_st_check;
                    end
                end

                c_st_check: begin
`ifdef NBR_RANGE_CHECK_EN
                    if (w_face_bad) begin
                        r_bad_index <= 1'b1;
                        r_pair      <= c_pairs_end;
                    end
`endif
                    r_state <= c_st_pair;
                end

                c_st_pair: begin
                    if (r_pair == c_pairs_end) begin
                        r_face_addr <= r_face_addr + ADDR_WIDTH'(3);
                        r_f         <= r_f + 32'd1;
                        if (r_f + 32'd1 == r_fcnt) begin
                            r_busy   <= 1'b0;
                            r_obj_en <= 1'b0;
                            r_nbr_en <= 1'b0;
                            r_state  <= c_st_done;
                        end else begin
                            r_sub   <= '0;
                            r_state <= c_st_fetch;
                        end
                    end else if (w_s == w_t) begin
                        r_pair <= r_pair + 3'd1;
                    end else begin
                        r_nbr_a <= w_s_base;
                        r_base  <= w_s_base;
                        r_t     <= w_t;
                        r_state <= c_st_read_cnt;
                    end
                end

                c_st_read_cnt: begin
                    r_cnt <= w_do_cnt;
                    if (w_do_cnt == '0) begin
                        r_state <= c_st_decide;
                    end else begin
                        r_nbr_a <= r_base + c_one;
                        r_idx   <= c_one;
                        r_state <= c_st_scan;
                    end
                end

                c_st_scan: begin
                    if (RAM_NBR_Do == r_t) begin
                        r_pair  <= r_pair + 3'd1;
                        r_state <= c_st_pair;
                    end else if (r_idx == r_cnt) begin
                        r_state <= c_st_decide;
                    end else begin
                        r_idx   <= r_idx + c_one;
                        r_nbr_a <= r_base + r_idx + c_one;
                    end
                end

                c_st_decide: begin
                    if (r_cnt < c_max_nbrs) begin
                        r_nbr_a  <= r_base + r_cnt + c_one;
                        r_nbr_di <= r_t;
                        r_nbr_we <= c_we_all;
                        r_state  <= c_st_write_cnt;
                    end else begin
                        r_overflow <= 1'b1;
                        r_pair     <= r_pair + 3'd1;
                        r_state    <= c_st_pair;
                    end
                end

                c_st_write_cnt: begin
                    r_nbr_a  <= r_base;
                    r_nbr_di <= 32'(r_cnt + c_one);
                    r_nbr_we <= c_we_all;
                    r_pair   <= r_pair + 3'd1;
                    r_state  <= c_st_pair;
                end

                c_st_done: begin
                    r_state <= c_st_idle;
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign RAM_OBJ_EN = r_obj_en;
    assign RAM_NBR_EN = r_nbr_en;
    assign RAM_OBJ_A  = r_obj_a;
    assign RAM_NBR_A  = r_nbr_a;
    assign RAM_OBJ_WE = 4'b0000;
    assign RAM_NBR_WE = r_nbr_we;
    assign RAM_OBJ_Di = 32'd0;
    assign RAM_NBR_Di = r_nbr_di;
    assign busy       = r_busy;
    assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_neighbor_builder.sv
// ============================================================================
// Module   : tb_neighbor_builder
// Brief    : Scoreboard bench for neighbor_builder with behavioural RAMs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_neighbor_builder;

    localparam int c_max = 10;
    localparam int c_aw  = 11;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [31:0]     vertex_count;
    logic [31:0]     face_count;
    logic [31:0]     obj_do;
    logic [31:0]     nbr_do;
    logic            obj_en, nbr_en;
    logic [c_aw-1:0] obj_a, nbr_a;
    logic [3:0]      obj_we, nbr_we;
    logic [31:0]     obj_di, nbr_di;
    logic            busy, overflow, bad_index;

    logic [31:0] obj_mem [0:(1<<c_aw)-1];
    logic [31:0] nbr_mem [0:(1<<c_aw)-1];

    typedef struct {
        int          kind;
        int          addr;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   batch_q[$];
    int   face_q[$];
    int   pend;
    int   checks = 0;
    int   errors = 0;
    logic busy_q = 1'b0;

    neighbor_builder #(.MAX_NEIGHBOR_COUNT(c_max), .ADDR_WIDTH(c_aw)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .vertex_count(vertex_count), .face_count(face_count),
        .RAM_OBJ_Do(obj_do), .RAM_NBR_Do(nbr_do),
        .RAM_OBJ_EN(obj_en), .RAM_NBR_EN(nbr_en),
        .RAM_OBJ_A(obj_a), .RAM_NBR_A(nbr_a),
        .RAM_OBJ_WE(obj_we), .RAM_NBR_WE(nbr_we),
        .RAM_OBJ_Di(obj_di), .RAM_NBR_Di(nbr_di),
        .busy(busy), .overflow(overflow), .bad_index(bad_index)
    );

    always #5 clk = ~clk;

    // Synchronous RAMs: address from the negedge, data back by the next negedge.
    always @(posedge clk) begin
        if (obj_en) obj_do <= obj_mem[obj_a];
        if (nbr_en) begin
            nbr_do <= nbr_mem[nbr_a];
            if (nbr_we == 4'hF) nbr_mem[nbr_a] = nbr_di;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({busy, obj_en, nbr_en, |nbr_we, |obj_we, |nbr_a, |obj_a,
                    |nbr_di, |obj_di, overflow, bad_index});
    endfunction

    task automatic push(input int kind, input int addr, input logic [31:0] val, input string name);
        exp_t e;
        e.kind = kind; e.addr = addr; e.val = val; e.name = name;
        exp_q.push_back(e);
        pend++;
    endtask

    task automatic exp_rec(input string tag, input int v, input int n, input int nb[9]);
        push(0, v * c_max, n, $sformatf("%s_v%0d_cnt", tag, v));
        for (int i = 0; i < n; i++)
            push(0, v * c_max + 1 + i, nb[i], $sformatf("%s_v%0d_w%0d", tag, v, i + 1));
    endtask

    task automatic exp_flags(input string tag, input logic ovf, input logic bad);
        push(1, 0, 32'(ovf), {tag, "_overflow"});
        push(2, 0, 32'(bad), {tag, "_bad_index"});
    endtask

    task automatic end_batch();
        batch_q.push_back(pend);
        pend = 0;
    endtask

    task automatic add_face(input int a, input int b, input int c);
        face_q.push_back(a); face_q.push_back(b); face_q.push_back(c);
    endtask

    task automatic load(input int v);
        int nf;
        nf = face_q.size() / 3;
        for (int i = 0; i < (1 << c_aw); i++) begin
            obj_mem[i] = 32'd0;
            nbr_mem[i] = (i < v * c_max) ? 32'h0000_DEAD : 32'd0;
        end
        obj_mem[0] = 32'(v);
        for (int i = 0; i < 3 * v; i++) obj_mem[1 + i] = 32'(i * 7);
        for (int i = 0; i < 3 * nf; i++) obj_mem[3 * v + 1 + i] = 32'(face_q[i]);
    endtask

    task automatic kick(input int v, input string tag);
        int nf;
        nf = face_q.size() / 3;
        load(v);
        face_q.delete();
        @(posedge clk); #1;
        vertex_count = 32'(v);
        face_count   = 32'(nf);
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    endtask

    task automatic run_build(input int v, input string tag);
        int n;
        kick(v, tag);
        n = 0;
        while (busy && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL %s_timeout: busy still %0d after %0d cycles expected 0", tag, busy, n);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: each fall of busy closes one scoreboard batch.
    always @(posedge clk) begin
        if (busy_q && !busy) begin
            if (batch_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: busy fell with no expected batch (0 expected)");
            end else begin
                int n;
                n = batch_q.pop_front();
                for (int i = 0; i < n; i++) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    case (e.kind)
                        0:       check(e.name, nbr_mem[e.addr], e.val);
                        1:       check(e.name, 32'(overflow), e.val);
                        2:       check(e.name, 32'(bad_index), e.val);
                        default: check(e.name, out_vec(), e.val);
                    endcase
                end
            end
        end
        busy_q = busy;
    end

    initial begin
        pend         = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        vertex_count = '0;
        face_count   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", out_vec(), 32'd0);
        rst_n = 1'b1;

        // Single triangle
        exp_rec("tri", 0, 2, '{2, 3, 0, 0, 0, 0, 0, 0, 0});
        exp_rec("tri", 1, 2, '{1, 3, 0, 0, 0, 0, 0, 0, 0});
        exp_rec("tri", 2, 2, '{1, 2, 0, 0, 0, 0, 0, 0, 0});
        exp_flags("tri", 1'b0, 1'b0);
        end_batch();
        add_face(1, 2, 3);
        run_build(3, "tri");

        // Quad as two triangles sharing edge 1-3
        exp_rec("quad", 0, 3, '{2, 3, 4, 0, 0, 0, 0, 0, 0});
        exp_rec("quad", 1, 2, '{1, 3, 0, 0, 0, 0, 0, 0, 0});
        exp_rec("quad", 2, 3, '{1, 2, 4, 0, 0, 0, 0, 0, 0});
        exp_rec("quad", 3, 2, '{1, 3, 0, 0, 0, 0, 0, 0, 0});
        exp_flags("quad", 1'b0, 1'b0);
        end_batch();
        add_face(1, 2, 3); add_face(1, 3, 4);
        run_build(4, "quad");

        // Fan of 12 triangles about vertex 1 overflows record 0
        exp_rec("fan", 0, 9, '{2, 3, 4, 5, 6, 7, 8, 9, 10});
        exp_rec("fan", 1, 2, '{1, 3, 0, 0, 0, 0, 0, 0, 0});
        exp_rec("fan", 13, 2, '{1, 13, 0, 0, 0, 0, 0, 0, 0});
        exp_flags("fan", 1'b1, 1'b0);
        end_batch();
        for (int k = 2; k <= 13; k++) add_face(1, k, k + 1);
        run_build(14, "fan");

        // Degenerate face: no self entries, vertex 1 stays empty
        exp_rec("degen", 0, 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0});
        exp_rec("degen", 1, 1, '{3, 0, 0, 0, 0, 0, 0, 0, 0});
        exp_rec("degen", 2, 1, '{2, 0, 0, 0, 0, 0, 0, 0, 0});
        exp_flags("degen", 1'b0, 1'b0);
        end_batch();
        add_face(2, 2, 3);
        run_build(3, "degen");

        // Reset mid-build, then a full rebuild
        push(3, 0, 32'd0, "abort_outputs");
        end_batch();
        add_face(1, 2, 3); add_face(1, 3, 4);
        kick(4, "abort");
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_rec("rebuild", 0, 3, '{2, 3, 4, 0, 0, 0, 0, 0, 0});
        exp_rec("rebuild", 2, 3, '{1, 2, 4, 0, 0, 0, 0, 0, 0});
        exp_flags("rebuild", 1'b0, 1'b0);
        end_batch();
        add_face(1, 2, 3); add_face(1, 3, 4);
        run_build(4, "rebuild");

        // Out-of-range corner
`ifdef NBR_RANGE_CHECK_EN
        exp_rec("range", 0, 2, '{2, 3, 0, 0, 0, 0, 0, 0, 0});
        exp_rec("range", 1, 2, '{1, 3, 0, 0, 0, 0, 0, 0, 0});
        exp_rec("range", 2, 2, '{1, 2, 0, 0, 0, 0, 0, 0, 0});
        exp_rec("range", 3, 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0});
        exp_flags("range", 1'b0, 1'b1);
`else
        exp_rec("range", 0, 3, '{2, 3, 5, 0, 0, 0, 0, 0, 0});
        exp_rec("range", 1, 3, '{1, 3, 5, 0, 0, 0, 0, 0, 0});
        exp_rec("range", 2, 2, '{1, 2, 0, 0, 0, 0, 0, 0, 0});
        exp_rec("range", 3, 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0});
        exp_rec("range", 4, 2, '{1, 2, 0, 0, 0, 0, 0, 0, 0});
        exp_flags("range", 1'b0, 1'b0);
`endif
        end_batch();
        add_face(1, 2, 3); add_face(1, 5, 2);
        run_build(4, "range");

        check("batches_drained", 32'(batch_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
